// File: rtl/clkrst_sequencer.sv
// clkrst_sequencer: PLL reset, lock qualification and ordered pherp/main reset release with key-triggered re-sequencing
module clkrst_sequencer #(
  parameter int PLL_RST_CYC      = 64,
  parameter int LOCK_TIMEOUT_CYC = 65535,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int STAGE_GAP_CYC    = 16,
  parameter int KEY_DEB_CYC      = 27000,
  parameter int CNT_W            = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       pll_lock_i,
  input  logic       key_i,
  output logic       pll_rst_o,
  output logic       pherp_rst_o,
  output logic       main_rst_o,
  output logic       ready_o,
  output logic [2:0] state_o,
  output logic [3:0] retry_cnt_o
);
  localparam logic [2:0] PLL_RST     = 3'd0;
  localparam logic [2:0] WAIT_LOCK   = 3'd1;
  localparam logic [2:0] LOCK_STABLE = 3'd2;
  localparam logic [2:0] REL_PHERP   = 3'd3;
  localparam logic [2:0] RUN         = 3'd4;
  localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(KEY_DEB_CYC - 1);
  logic [1:0]       lock_sync, key_sync;
  logic             lock_s, key_s, key_acc, deb_done, press, retry_inc, enter;
  logic [CNT_W-1:0] timer, deb_cnt;
  logic [2:0]       state, nxt;
  assign lock_s   = lock_sync[1];
  assign key_s    = key_sync[1];
  assign deb_done = (key_s != key_acc) && (deb_cnt == DEB_LAST);
  assign press    = deb_done && key_s;
  assign enter    = press || (nxt != state);
  assign state_o  = state;
  always_comb begin
    nxt       = PLL_RST;
    retry_inc = 1'b0;
    if (!press)
      case (state)
        PLL_RST:     nxt = (timer == PLL_LAST) ? WAIT_LOCK : PLL_RST;
        WAIT_LOCK: begin
          retry_inc = timer == TIMEOUT_LAST;
          nxt       = retry_inc ? PLL_RST : lock_s ? LOCK_STABLE : WAIT_LOCK;
        end
        LOCK_STABLE: nxt = !lock_s ? WAIT_LOCK : (timer == STABLE_LAST) ? REL_PHERP : LOCK_STABLE;
        REL_PHERP: begin
          retry_inc = !lock_s;
          nxt       = !lock_s ? WAIT_LOCK : (timer == GAP_LAST) ? RUN : REL_PHERP;
        end
        RUN: begin
          retry_inc = !lock_s;
          nxt       = lock_s ? RUN : WAIT_LOCK;
        end
        default:     nxt = PLL_RST;
      endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      lock_sync <= '0;
      key_sync  <= '0;
      key_acc   <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      lock_sync <= {lock_sync[0], pll_lock_i};
      key_sync  <= {key_sync[0], key_i};
      deb_cnt   <= (key_s == key_acc || deb_done) ? '0 : deb_cnt + CNT_W'(1);
      key_acc   <= deb_done ? key_s : key_acc;
    end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state       <= PLL_RST;
      timer       <= '0;
      retry_cnt_o <= '0;
      pll_rst_o   <= 1'b1;
      pherp_rst_o <= 1'b1;
      main_rst_o  <= 1'b1;
      ready_o     <= 1'b0;
    end else begin
      state       <= nxt;
      timer       <= enter ? '0 : timer + CNT_W'(1);
      retry_cnt_o <= (retry_inc && retry_cnt_o != 4'hf) ? retry_cnt_o + 4'd1 : retry_cnt_o;
      pll_rst_o   <= nxt == PLL_RST;
      pherp_rst_o <= nxt != REL_PHERP && nxt != RUN;
      main_rst_o  <= nxt != RUN;
      ready_o     <= nxt == RUN;
    end
endmodule
